// File: rtl/am_pkg.sv
// Alignment-marker constants and lane FSM encoding shared by the lock logic.
// Marker bytes are packed with the first transmitted byte in the least significant position.
package am_pkg;

  localparam logic [1:0] AM_SYNC_HDR = 2'b01;

  localparam logic [47:0] AM_PAT0 = 48'hB8_89_6F_47_76_90;
  localparam logic [47:0] AM_PAT1 = 48'h19_3B_0F_E6_C4_F0;
  localparam logic [47:0] AM_PAT2 = 48'h64_9A_3A_9B_65_C5;
  localparam logic [47:0] AM_PAT3 = 48'hC2_86_5D_3D_79_A2;

  typedef enum logic [1:0] {
    ST_FIND    = 2'd0,
    ST_COUNT_1 = 2'd1,
    ST_COUNT_2 = 2'd2
  } am_state_t;

  function automatic logic [47:0] am_pattern(input logic [1:0] idx);
    case (idx)
      2'd0:    am_pattern = AM_PAT0;
      2'd1:    am_pattern = AM_PAT1;
      2'd2:    am_pattern = AM_PAT2;
      default: am_pattern = AM_PAT3;
    endcase
  endfunction

endpackage

// File: rtl/am_lock_lane.sv
// Per-lane alignment-marker lock FSM: hunts for a marker, confirms it one period later,
// then tracks consecutive check-word misses until the limit drops lock.
module am_lock_lane
  import am_pkg::*;
#(
  parameter int AM_PERIOD  = 16384,
  parameter int MISS_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [49:0] word,
  input  logic        data_valid,
  input  logic        block_lock,
  output logic        am_lock,
  output logic [1:0]  lane_map,
  output logic        lock_lost,
  output am_state_t   state
);

  localparam int CW = $clog2(AM_PERIOD);

  logic [CW-1:0] word_cnt;
  logic [2:0]    miss_cnt;
  logic          marker_hit;
  logic [1:0]    marker_idx;
  logic          check_word;
  logic          check_match;
  logic          miss_final;

  always_comb begin
    marker_hit = 1'b0;
    marker_idx = 2'd0;
    if (word[1:0] == AM_SYNC_HDR) begin
      for (int i = 0; i < 4; i++) begin
        if (word[49:2] == am_pattern(2'(i))) begin
          marker_hit = 1'b1;
          marker_idx = 2'(i);
        end
      end
    end
  end

  // A different valid marker on the check word still counts as a miss.
  assign check_match = (word == {am_pattern(lane_map), AM_SYNC_HDR});
  assign check_word  = (word_cnt == CW'(AM_PERIOD - 1));
  assign miss_final  = (miss_cnt == 3'(MISS_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_FIND;
      word_cnt  <= '0;
      miss_cnt  <= '0;
      am_lock   <= 1'b0;
      lane_map  <= 2'd0;
      lock_lost <= 1'b0;
    end else if (!block_lock) begin
      state     <= ST_FIND;
      word_cnt  <= '0;
      miss_cnt  <= '0;
      am_lock   <= 1'b0;
      lock_lost <= am_lock;
    end else begin
      lock_lost <= 1'b0;
      if (data_valid) begin
        case (state)
          ST_FIND: begin
            if (marker_hit) begin
              lane_map <= marker_idx;
              word_cnt <= '0;
              state    <= ST_COUNT_1;
            end
          end
          ST_COUNT_1: begin
            word_cnt <= word_cnt + 1'b1;
            if (check_word) begin
              if (check_match) begin
                state    <= ST_COUNT_2;
                am_lock  <= 1'b1;
                miss_cnt <= '0;
              end else begin
                state <= ST_FIND;
              end
            end
          end
          ST_COUNT_2: begin
            word_cnt <= word_cnt + 1'b1;
            if (check_word) begin
              if (check_match) begin
                miss_cnt <= '0;
              end else if (miss_final) begin
                state     <= ST_FIND;
                am_lock   <= 1'b0;
                lock_lost <= 1'b1;
                miss_cnt  <= '0;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end
          end
          default: state <= ST_FIND;
        endcase
      end
    end
  end

endmodule

// File: rtl/am_align_lock.sv
// Multi-lane alignment-marker lock: one lock FSM per lane plus registered
// duplicate-mapping detection and all-lanes-locked aggregation.
module am_align_lock
  import am_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int AM_PERIOD  = 16384,
  parameter int MISS_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_LANES*50-1:0] data_in,
  input  logic                   data_valid,
  input  logic [NUM_LANES-1:0]   block_lock,
  output logic [NUM_LANES-1:0]   am_lock,
  output logic [NUM_LANES*2-1:0] lane_mapping,
  output logic [NUM_LANES-1:0]   lock_lost,
  output logic                   all_locked,
  output logic                   dup_lane,
  output logic [NUM_LANES*2-1:0] dbg_state
);

  logic dup_c;

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    am_state_t lane_state;

    am_lock_lane #(
      .AM_PERIOD (AM_PERIOD),
      .MISS_LIMIT(MISS_LIMIT)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .word      (data_in[50*n +: 50]),
      .data_valid(data_valid),
      .block_lock(block_lock[n]),
      .am_lock   (am_lock[n]),
      .lane_map  (lane_mapping[2*n +: 2]),
      .lock_lost (lock_lost[n]),
      .state     (lane_state)
    );

    assign dbg_state[2*n +: 2] = lane_state;
  end

  // Only locked lanes take part in the uniqueness check.
  always_comb begin
    dup_c = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      for (int j = i + 1; j < NUM_LANES; j++) begin
        if (am_lock[i] && am_lock[j] &&
            (lane_mapping[2*i +: 2] == lane_mapping[2*j +: 2])) begin
          dup_c = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dup_lane   <= 1'b0;
      all_locked <= 1'b0;
    end else begin
      dup_lane   <= dup_c;
      all_locked <= (&am_lock) && !dup_c;
    end
  end

endmodule

// File: tb/tb_am_align_lock.sv
// Randomized bench for am_align_lock against a per-lane reference model that
// tracks words-since-marker and miss history in plain integers.
module tb_am_align_lock;

  localparam int NL = 4;
  localparam int P  = 16;
  localparam int ML = 4;
  localparam int W  = 2 + NL + 2*NL + NL;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NL*50-1:0]  data_in = '0;
  logic              data_valid = 1'b0;
  logic [NL-1:0]     block_lock = '1;
  logic [NL-1:0]     am_lock;
  logic [NL*2-1:0]   lane_mapping;
  logic [NL-1:0]     lock_lost;
  logic              all_locked;
  logic              dup_lane;
  logic [NL*2-1:0]   dbg_state;

  am_align_lock #(.NUM_LANES(NL), .AM_PERIOD(P), .MISS_LIMIT(ML)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .block_lock(block_lock), .am_lock(am_lock), .lane_mapping(lane_mapping),
    .lock_lost(lock_lost), .all_locked(all_locked), .dup_lane(dup_lane),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Marker bytes in transmission order.
  logic [7:0] am_bytes [4][6] = '{
    '{8'h90, 8'h76, 8'h47, 8'h6F, 8'h89, 8'hB8},
    '{8'hF0, 8'hC4, 8'hE6, 8'h0F, 8'h3B, 8'h19},
    '{8'hC5, 8'h65, 8'h9B, 8'h3A, 8'h9A, 8'h64},
    '{8'hA2, 8'h79, 8'h3D, 8'h5D, 8'h86, 8'hC2}
  };

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [49:0] mk(input int idx);
    logic [49:0] w;
    w[1:0] = 2'b01;
    for (int b = 0; b < 6; b++) w[2+8*b +: 8] = am_bytes[idx][b];
    return w;
  endfunction

  function automatic logic [49:0] rnd_word();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[49:0];
  endfunction

  // Reference model state
  bit        m_hunt [NL];
  bit        m_conf [NL];
  bit        m_lock [NL];
  bit        m_ll   [NL];
  int        m_since[NL];
  int        m_miss [NL];
  logic [1:0] m_map [NL];
  bit        m_dup, m_all;

  task automatic model_reset();
    for (int n = 0; n < NL; n++) begin
      m_hunt[n] = 1; m_conf[n] = 0; m_lock[n] = 0; m_ll[n] = 0;
      m_since[n] = 0; m_miss[n] = 0; m_map[n] = 2'd0;
    end
    m_dup = 0; m_all = 0;
  endtask

  task automatic model_step();
    bit dup_n, all_n;
    logic [49:0] w;
    bit match;
    if (!reset) begin
      model_reset();
      return;
    end
    dup_n = 0; all_n = 1;
    for (int i = 0; i < NL; i++) begin
      if (!m_lock[i]) all_n = 0;
      for (int j = i + 1; j < NL; j++)
        if (m_lock[i] && m_lock[j] && m_map[i] == m_map[j]) dup_n = 1;
    end
    m_dup = dup_n;
    m_all = all_n && !dup_n;
    for (int n = 0; n < NL; n++) begin
      m_ll[n] = 0;
      w = data_in[50*n +: 50];
      if (!block_lock[n]) begin
        m_ll[n] = m_lock[n];
        m_lock[n] = 0; m_hunt[n] = 1; m_miss[n] = 0;
      end else if (data_valid) begin
        if (m_hunt[n]) begin
          for (int k = 0; k < 4; k++)
            if (w == mk(k)) begin
              m_map[n] = 2'(k); m_hunt[n] = 0; m_conf[n] = 0; m_since[n] = 0;
            end
        end else begin
          m_since[n]++;
          if (m_since[n] % P == 0) begin
            match = (w == mk(int'(m_map[n])));
            if (!m_conf[n]) begin
              if (match) begin m_conf[n] = 1; m_lock[n] = 1; m_miss[n] = 0; end
              else m_hunt[n] = 1;
            end else if (match) begin
              m_miss[n] = 0;
            end else begin
              m_miss[n]++;
              if (m_miss[n] == ML) begin
                m_hunt[n] = 1; m_lock[n] = 0; m_ll[n] = 1; m_miss[n] = 0;
              end
            end
          end
        end
      end
    end
  endtask

  function automatic logic [W-1:0] pack_exp();
    logic [W-1:0] e;
    e = '0;
    for (int n = 0; n < NL; n++) begin
      e[n]            = m_lock[n];
      e[NL+2*n +: 2]  = m_map[n];
      e[3*NL+n]       = m_ll[n];
    end
    e[4*NL]   = m_dup;
    e[4*NL+1] = m_all;
    return e;
  endfunction

  // Stimulus state
  int plan[NL];
  int off[NL];
  int hold[NL];
  int g = 0;
  int p_good = 97;

  task automatic drive_next(input bit rst_n);
    int r;
    reset = rst_n;
    data_valid = ($urandom_range(0, 99) < 85);
    for (int n = 0; n < NL; n++) begin
      if (data_valid && (g % P == off[n])) begin
        r = $urandom_range(0, 99);
        if (r < p_good) data_in[50*n +: 50] = mk(plan[n]);
        else if (r < p_good + 5) data_in[50*n +: 50] = mk($urandom_range(0, 3));
        else data_in[50*n +: 50] = rnd_word();
      end else if ($urandom_range(0, 63) == 0) begin
        data_in[50*n +: 50] = mk($urandom_range(0, 3));
      end else begin
        data_in[50*n +: 50] = rnd_word();
      end
      if (hold[n] == 0 && $urandom_range(0, 999) == 0) hold[n] = $urandom_range(1, 3);
      block_lock[n] = (hold[n] == 0);
      if (hold[n] > 0) hold[n]--;
    end
    if (data_valid) g++;
  endtask

  task automatic run_cycles(input int cycles, input int rst_at);
    logic [W-1:0] e;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      model_step();
      exp_q.push_back(pack_exp());
      #1;
      if (exp_q.size() == 0) begin
        check("queue_empty", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("am_lock",      32'(am_lock),      32'(e[NL-1:0]));
        check("lane_mapping", 32'(lane_mapping), 32'(e[NL +: 2*NL]));
        check("lock_lost",    32'(lock_lost),    32'(e[3*NL +: NL]));
        check("dup_lane",     32'(dup_lane),     32'(e[4*NL]));
        check("all_locked",   32'(all_locked),   32'(e[4*NL+1]));
      end
      drive_next(!(c >= rst_at && c < rst_at + 2));
    end
  endtask

  int saw_lock, saw_all, saw_dup, saw_lost;
  always @(negedge clk) begin
    if (am_lock != 0) saw_lock++;
    if (all_locked) saw_all++;
    if (dup_lane) saw_dup++;
    if (lock_lost != 0) saw_lost++;
  end

  initial begin
    model_reset();
    for (int n = 0; n < NL; n++) begin
      hold[n] = 0; plan[n] = n; off[n] = $urandom_range(0, P-1);
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_am_lock", 32'(am_lock), 32'd0);
    check("rst_mapping", 32'(lane_mapping), 32'd0);
    check("rst_outputs", 32'({lock_lost, all_locked, dup_lane}), 32'd0);
    drive_next(1'b1);

    // Unique plans: lanes should reach all_locked.
    p_good = 97;
    run_cycles(2500, -10);

    // Random plans with frequent misses: duplicates and lock losses.
    p_good = 70;
    for (int n = 0; n < NL; n++) begin
      plan[n] = $urandom_range(0, 3); off[n] = $urandom_range(0, P-1);
    end
    run_cycles(2500, -10);

    // Relock on new unique plans, with a reset pulse in the middle.
    p_good = 97;
    for (int n = 0; n < NL; n++) begin
      plan[n] = (n + 1) % NL; off[n] = $urandom_range(0, P-1);
    end
    run_cycles(1500, 900);

    check("coverage_lock", 32'(saw_lock > 0), 32'd1);
    check("coverage_lost", 32'(saw_lost > 0), 32'd1);
    $display("coverage: lock=%0d all=%0d dup=%0d lost=%0d", saw_lock, saw_all, saw_dup, saw_lost);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/am_align_lock.md
AM_ALIGN_LOCK -- requirements
Module: am_align_lock

Interface
REQ-001 Parameter NUM_LANES, 4, number of PCS lanes processed in parallel (1..16).
REQ-002 Parameter AM_PERIOD, 16384, valid words between consecutive alignment markers (power of two, >=8).
REQ-003 Parameter MISS_LIMIT, 4, consecutive marker mismatches in lock that cause lock loss (1..7).
REQ-004 Port clk  input  1  single clock for all logic.
REQ-005 Port reset  input  1  reset, synchronous and active-low.
REQ-006 Port data_in  input  NUM_LANES*50  per-lane 50-bit word: bits [1:0] sync header, bits [49:2] six marker bytes, LSB byte first; lane n at [50n+49:50n].
REQ-007 Port data_valid  input  1  common qualifier; a word is accepted on every lane only when high.
REQ-008 Port block_lock  input  NUM_LANES  per-lane block lock from the block-sync stage.
REQ-009 Port am_lock  output  NUM_LANES  per-lane alignment-marker lock.
REQ-010 Port lane_mapping  output  NUM_LANES*2  per-lane index (0..3) of the captured marker pattern.
REQ-011 Port lock_lost  output  NUM_LANES  one-cycle pulse when am_lock[n] falls.
REQ-012 Port all_locked  output  1  all lanes locked and mapping unique.
REQ-013 Port dup_lane  output  1  two or more locked lanes report the same lane_mapping.

Function
REQ-014 Marker valid: sync header 2'b01 and bytes [49:2] equal one of four package patterns (idx0 90 76 47 6F 89 B8, idx1 F0 C4 E6 0F 3B 19, idx2 C5 65 9B 3A 9A 64, idx3 A2 79 3D 5D 86 C2).
REQ-015 Each lane shall run an independent FSM with states FIND, COUNT_1, COUNT_2; state, word counter, miss counter advance only on cycles with data_valid high.
REQ-016 FIND: a valid marker word captures its pattern index into lane_mapping, clears the word counter to 0, moves to COUNT_1; otherwise stays in FIND.
REQ-017 Word counter is log2(AM_PERIOD) bits, increments per accepted word after the marker, wraps to 0; the word accepted when counter == AM_PERIOD-1 is the check word.
REQ-018 Check match: check word equals the captured pattern (header and all six bytes); any other word, including a different valid pattern, is a mismatch.
REQ-019 COUNT_1 check: match -> COUNT_2, am_lock set, miss counter 0; mismatch -> FIND, am_lock stays 0.
REQ-020 COUNT_2 check: match -> miss counter 0; mismatch -> miss counter +1; the MISS_LIMIT-th consecutive mismatch -> FIND, am_lock cleared.
REQ-021 Outputs are registered: am_lock changes on the clock edge that accepts the check word, visible the following cycle.
REQ-022 block_lock[n] low: lane n enters FIND, clears counters and am_lock on the next edge, regardless of data_valid.
REQ-023 lock_lost[n] pulses exactly one cycle whenever am_lock[n] goes 1->0 (miss limit or block_lock loss), never on reset.
REQ-024 lane_mapping holds its value until the next capture in FIND; outputs 0 before first capture.
REQ-025 dup_lane and all_locked are registered, one cycle after am_lock/lane_mapping; all_locked = AND of am_lock and not dup_lane.
REQ-026 In FIND, a marker on a data_valid-low cycle is ignored.

Reset
REQ-027 reset low at a clock edge forces every lane to FIND and all outputs, counters and captured indices to 0, overriding all other inputs including mid-lock.

Structure
REQ-028 Package am_pkg holds the four 48-bit marker patterns, the 2'b01 header constant and the FSM state encoding.
REQ-029 Per-lane FSM and counters form sub-module am_lock_lane, generated NUM_LANES times; top holds only the duplicate check and aggregation.

Verification (AM_PERIOD=16, MISS_LIMIT=4, NUM_LANES=4)
REQ-030 Lane0 idx2 marker at accepted words 0 and 16 -> am_lock[0]=1 cycle after word 16, lane_mapping lane0=2.
REQ-031 Lane1 idx0 at word 0, idx1 at word 16 -> am_lock[1] stays 0, lane returns to FIND, relocks on next idx0 pair.
REQ-032 Locked lane0: 3 mismatched checks then match -> am_lock stays 1; then 4 mismatches -> am_lock falls after 4th, lock_lost[0] one cycle.
REQ-033 data_valid low 5 cycles mid-period -> check word and am_lock rise delayed exactly 5 cycles.
REQ-034 Lanes 0..3 locked on idx 0,1,2,2 -> dup_lane=1, all_locked=0; relock lane3 on idx3 -> dup_lane=0, all_locked=1.
REQ-035 block_lock[2] low in COUNT_2 -> am_lock[2]=0 and lock_lost[2] pulse next cycle; reset low while all locked -> all outputs 0, no lock_lost.
